// File: rtl/mmio_bridge_pkg.sv
// Shared defaults for the MMIO bridge: bus widths, FSM encodings and the
// standard peripheral map (RAM, keyboard, RTC, seg/led).
package mmio_bridge_pkg;

    localparam int unsigned NSLV_DEF = 4;
    localparam int unsigned AW_DEF   = 64;
    localparam int unsigned DW_DEF   = 64;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [63:0] RAM_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] RAM_LEN  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] KBD_BASE = 64'h0000_0000_a000_0060;
    localparam logic [63:0] KBD_LEN  = 64'h0000_0000_0000_0008;
    localparam logic [63:0] RTC_BASE = 64'h0000_0000_a000_0048;
    localparam logic [63:0] RTC_LEN  = 64'h0000_0000_0000_0008;
    localparam logic [63:0] SEG_BASE = 64'h0000_0000_a000_0100;
    localparam logic [63:0] SEG_LEN  = 64'h0000_0000_0000_0020;

    // Slot 0 sits in the least-significant word.
    localparam logic [NSLV_DEF*AW_DEF-1:0] SLV_BASE_DEF = {SEG_BASE, RTC_BASE, KBD_BASE, RAM_BASE};
    localparam logic [NSLV_DEF*AW_DEF-1:0] SLV_LEN_DEF  = {SEG_LEN,  RTC_LEN,  KBD_LEN,  RAM_LEN};

endpackage

// File: rtl/mmio_bridge_if.sv
// Core-side request/response channel of the MMIO bridge.
interface mmio_bridge_if
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              req_wen;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mmio_addr_dec.sv
// Combinational window match over all slots; the lowest matching index wins.
module mmio_addr_dec
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned NSLV = NSLV_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned SW   = 2,
    parameter logic [NSLV*AW-1:0] SLV_BASE = SLV_BASE_DEF,
    parameter logic [NSLV*AW-1:0] SLV_LEN  = SLV_LEN_DEF
) (
    input  logic [AW-1:0] addr,
    output logic          hit_c,
    output logic [SW-1:0] sel_c,
    output logic [AW-1:0] offset_c
);

    logic [AW-1:0] base_v;
    logic [AW-1:0] len_v;

    // Scan high to low so a lower-index match overrides; subtraction form is overflow-safe.
    always_comb begin
        hit_c    = 1'b0;
        sel_c    = '0;
        offset_c = '0;
        base_v   = '0;
        len_v    = '0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            base_v = SLV_BASE[i*AW +: AW];
            len_v  = SLV_LEN[i*AW +: AW];
            if ((addr >= base_v) && ((addr - base_v) < len_v)) begin
                hit_c    = 1'b1;
                sel_c    = SW'(i);
                offset_c = addr - base_v;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// MMIO bridge: decodes core requests onto one peripheral slot, reports
// unmapped/timeout accesses as bus errors and records the last fault address.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned NSLV  = NSLV_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter logic [NSLV*AW-1:0] SLV_BASE = SLV_BASE_DEF,
    parameter logic [NSLV*AW-1:0] SLV_LEN  = SLV_LEN_DEF,
    parameter int unsigned TMO   = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_bridge_if.slave         bus,
    output logic [NSLV-1:0]      slv_valid,
    input  logic [NSLV-1:0]      slv_ready,
    output logic [AW-1:0]        slv_addr,
    output logic                 slv_wen,
    output logic [DW-1:0]        slv_wdata,
    output logic [DW/8-1:0]      slv_wstrb,
    input  logic [NSLV*DW-1:0]   slv_rdata,
    output logic [AW-1:0]        err_addr,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int unsigned BW = DW / 8;
    localparam logic [TW-1:0]   TMO_LAST = TW'((TMO == 0) ? 0 : TMO - 1);
    localparam logic [NSLV-1:0] SLOT_ONE = NSLV'(1);

    state_t           state, state_n;
    logic [SW-1:0]    sel_q, sel_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [TW-1:0]    tmo_cnt, tmo_n;
    logic [NSLV-1:0]  valid_n;
    logic [AW-1:0]    saddr_n;
    logic             wen_n;
    logic [DW-1:0]    wdata_n;
    logic [BW-1:0]    wstrb_n;
    logic             ready_r, ready_n;
    logic             rvalid_r, rvalid_n;
    logic [DW-1:0]    rdata_r, rdata_n;
    logic             rerr_r, rerr_n;
    logic [AW-1:0]    eaddr_n;
    logic [CNT_W-1:0] ecnt_n, ecnt_inc;
    logic [DW-1:0]    rdata_sel;
    logic             ready_sel;
    logic             dec_hit;
    logic [SW-1:0]    dec_sel;
    logic [AW-1:0]    dec_off;

    mmio_addr_dec #(
        .NSLV     (NSLV),
        .AW       (AW),
        .SW       (SW),
        .SLV_BASE (SLV_BASE),
        .SLV_LEN  (SLV_LEN)
    ) u_dec (
        .addr     (bus.req_addr),
        .hit_c    (dec_hit),
        .sel_c    (dec_sel),
        .offset_c (dec_off)
    );

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = rvalid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = rerr_r;

    assign ecnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        addr_n    = addr_q;
        tmo_n     = tmo_cnt;
        valid_n   = slv_valid;
        saddr_n   = slv_addr;
        wen_n     = slv_wen;
        wdata_n   = slv_wdata;
        wstrb_n   = slv_wstrb;
        ready_n   = ready_r;
        rvalid_n  = rvalid_r;
        rdata_n   = rdata_r;
        rerr_n    = rerr_r;
        eaddr_n   = err_addr;
        ecnt_n    = err_cnt;
        rdata_sel = '0;
        ready_sel = 1'b0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (sel_q == SW'(i)) begin
                rdata_sel = slv_rdata[i*DW +: DW];
                ready_sel = slv_ready[i];
            end
        end
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    ready_n = 1'b0;
                    addr_n  = bus.req_addr;
                    if (dec_hit) begin
                        state_n = ST_REQ;
                        sel_n   = dec_sel;
                        valid_n = SLOT_ONE << dec_sel;
                        saddr_n = dec_off;
                        wen_n   = bus.req_wen;
                        wdata_n = bus.req_wdata;
                        wstrb_n = bus.req_wstrb;
                        tmo_n   = '0;
                    end else begin
                        state_n  = ST_RESP;
                        rvalid_n = 1'b1;
                        rdata_n  = '0;
                        rerr_n   = 1'b1;
                        eaddr_n  = bus.req_addr;
                        ecnt_n   = ecnt_inc;
                    end
                end
            end
            ST_REQ: begin
                // Ready in the final allowed cycle still completes without error.
                if (ready_sel) begin
                    state_n  = ST_RESP;
                    valid_n  = '0;
                    rvalid_n = 1'b1;
                    rdata_n  = slv_wen ? '0 : rdata_sel;
                    rerr_n   = 1'b0;
                end else if ((TMO != 0) && (tmo_cnt == TMO_LAST)) begin
                    state_n  = ST_RESP;
                    valid_n  = '0;
                    rvalid_n = 1'b1;
                    rdata_n  = '0;
                    rerr_n   = 1'b1;
                    eaddr_n  = addr_q;
                    ecnt_n   = ecnt_inc;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_n  = ST_IDLE;
                    rvalid_n = 1'b0;
                    ready_n  = 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                valid_n  = '0;
                rvalid_n = 1'b0;
                ready_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            tmo_cnt   <= '0;
            slv_valid <= '0;
            slv_addr  <= '0;
            slv_wen   <= 1'b0;
            slv_wdata <= '0;
            slv_wstrb <= '0;
            ready_r   <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rerr_r    <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            sel_q     <= sel_n;
            addr_q    <= addr_n;
            tmo_cnt   <= tmo_n;
            slv_valid <= valid_n;
            slv_addr  <= saddr_n;
            slv_wen   <= wen_n;
            slv_wdata <= wdata_n;
            slv_wstrb <= wstrb_n;
            ready_r   <= ready_n;
            rvalid_r  <= rvalid_n;
            rdata_r   <= rdata_n;
            rerr_r    <= rerr_n;
            err_addr  <= eaddr_n;
            err_cnt   <= ecnt_n;
        end
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Parametrised MMIO bridge between the core's load/store unit and NSLV peripheral slots (RAM, keyboard, RTC, seg/led, ...). Decodes each request against per-slot base/length windows. Forwards the request over a valid/ready handshake to exactly one slot and returns a registered response. Unmapped addresses and slot timeouts are reported as bus errors, and the address of the most recent fault is captured for debug.

Parameters:
NSLV, 4, number of peripheral slots
AW, 64, address width
DW, 64, data width; strobe width is DW/8
SLV_BASE, {0xa000_0100, 0xa000_0048, 0xa000_0060, 0x8000_0000}, packed NSLV*AW base addresses, slot 0 in LSBs
SLV_LEN, {0x20, 0x8, 0x8, 0x0800_0000}, packed NSLV*AW window lengths in bytes
TMO, 16, cycles a slot may stall before a timeout error; 0 disables the timeout
CNT_W, 8, width of the error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  master request valid
req_ready  out  1  bridge can accept a request
req_addr  in  AW  byte address
req_wen  in  1  1 = write, 0 = read
req_wdata  in  DW  write data
req_wstrb  in  DW/8  write byte enables
resp_valid  out  1  response valid
resp_ready  in  1  master accepts the response
resp_rdata  out  DW  read data; 0 for writes and errors
resp_err  out  1  decode or timeout error
slv_valid  out  NSLV  one-hot request strobe per slot
slv_ready  in  NSLV  per-slot acceptance/completion
slv_addr  out  AW  slot-relative offset (req_addr - SLV_BASE[sel])
slv_wen  out  1  broadcast write enable
slv_wdata  out  DW  broadcast write data
slv_wstrb  out  DW/8  broadcast strobes
slv_rdata  in  NSLV*DW  per-slot read data, slot 0 in LSBs
err_addr  out  AW  address of the last faulting request
err_cnt  out  CNT_W  saturating count of errors

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; all slv_valid=0; resp_valid=0; resp_err=0; resp_rdata=0; err_addr=0; err_cnt=0; timeout counter=0.
  - rst asserted mid-transaction abandons the transaction; no response is issued.
- FSM has three states: IDLE, REQ, RESP. req_ready=1 only in IDLE.
- Decode:
  - hit[i] = (addr >= SLV_BASE[i]) && (addr - SLV_BASE[i] < SLV_LEN[i]); the subtraction form avoids overflow at the top of the space.
  - Overlapping windows: the lowest index wins.
  - Decode is combinational on req_addr and is registered at accept together with addr, wen, wdata and wstrb.
- IDLE:
  - On req_valid && req_ready with a hit: latch sel and the request, go to REQ.
  - With no hit: go to RESP with resp_err=1 and resp_rdata=0, err_addr<=req_addr, err_cnt+1 (saturating at all-ones).
- REQ:
  - slv_valid[sel]=1, all other bits 0; slv_* outputs are stable for the whole state.
  - On slv_ready[sel]: capture slv_rdata[sel] (reads) or 0 (writes), resp_err=0, go to RESP.
  - Timeout counter starts at 0 on entry and increments each REQ cycle without slv_ready[sel].
  - If TMO!=0 and the counter reaches TMO-1 without ready: drop slv_valid, go to RESP with err=1, rdata=0, err_addr and err_cnt updated.
  - If ready arrives in the same cycle the counter reaches TMO-1, ready wins and there is no error.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready go to IDLE. A new request is accepted at the earliest one cycle later (no same-cycle turnaround).
- Latency:
  - Hit with slv_ready tied 1: accept edge E0 -> slv_valid during cycle E0..E1 -> resp_valid after E1, i.e. 2 cycles.
  - Decode error: resp_valid 1 cycle after accept.
- Handshakes:
  - Master must hold req_* while req_valid && !req_ready.
  - slv_ready is sampled only for the selected slot; ready on any other slot is ignored.
- Width rules:
  - slv_addr is computed at full AW width.
  - err_cnt saturates and never wraps.

Decomposition:
- Shared package: AW/DW defaults, FSM state typedef (IDLE/REQ/RESP), default slot base/length constants (RAM, KBD, RTC, SEG/LED addresses).
- One sub-module, mmio_addr_dec: purely combinational NSLV-way window match plus priority encoder. Outputs sel index, hit flag and slot offset.

Test Plan:
1. Read 0x8000_0010, slot0 ready=1, slv_rdata0=0x1122334455667788 -> slv_valid=0001, slv_addr=0x10, resp_valid 2 cycles after accept, rdata=0x1122334455667788, err=0.
2. Write 0xa000_0104 data 0xdead_beef strb 0x0f, slot3 ready after 3 cycles -> slv_valid=1000 held 4 cycles, slv_addr=0x4, resp rdata=0, err=0.
3. Read 0x0000_1000 (unmapped) -> resp_valid 1 cycle after accept, err=1, rdata=0, err_addr=0x1000, err_cnt=1; no slv_valid pulse.
4. Read 0xa000_0060 with slot1 ready stuck 0, TMO=16 -> slv_valid drops after 16 cycles, err=1, err_addr=0xa000_0060; then ready arriving exactly at cycle 16 -> no error.
5. resp_ready held 0 for 5 cycles -> resp_valid/rdata/err stable, req_ready=0, new req_valid ignored; rst asserted during REQ -> next cycle IDLE, slv_valid=0, no response.
6. 300 consecutive decode errors with CNT_W=8 -> err_cnt saturates at 0xff.
